// File: rtl/inst_rom_loader_if.sv
// Bundle for the core fetch port and the byte-serial loader handshake.
// The slave side is the instruction memory; the master side is the core plus loader.
interface inst_rom_loader_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_data_i;
  logic        ld_last_i;
  logic        ld_ready_o;

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
    output rom_data_o, ld_ready_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_valid_i, ld_data_i, ld_last_i,
    input  rom_data_o, ld_ready_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction memory for the MIPS core, filled big-endian by a byte-serial loader.
// Keeps the core in reset until a complete image has been loaded.
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_rom_loader_if.slave      bus,
  output logic                  cpu_rst_o,
  output logic [ADDR_WIDTH:0]   ld_words_o,
  output logic                  ld_overflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_RUN
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [31:0]           mem [DEPTH];
  logic [1:0]            lane;
  logic [23:0]           held;
  logic [ADDR_WIDTH:0]   word_ptr;
  logic                  overflow;
  logic                  cpu_rst;

  logic                  ready;
  logic                  accept;
  logic                  word_done;
  logic                  full;
  logic                  wr_en;
  logic [31:0]           word_asm;
  logic                  unused_addr;

  // A reset cycle never writes the array, so a half-built word is dropped.
  always_comb begin
    ready     = (state == S_LOAD) && !bus.ld_start_i;
    accept    = bus.ld_valid_i && ready && !rst;
    word_done = accept && ((lane == 2'd3) || bus.ld_last_i);
    full      = word_ptr[ADDR_WIDTH];
    wr_en     = word_done && !full;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    word_asm = 32'h0;
    unique case (lane)
      2'd0: word_asm = {bus.ld_data_i, 24'h0};
      2'd1: word_asm = {held[23:16], bus.ld_data_i, 16'h0};
      2'd2: word_asm = {held[23:8], bus.ld_data_i, 8'h0};
      2'd3: word_asm = {held, bus.ld_data_i};
      default: word_asm = 32'h0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_HOLD: if (bus.ld_start_i) state_next = S_LOAD;
      S_LOAD: begin
        if (bus.ld_start_i) begin
          state_next = S_LOAD;
        end else if (accept && bus.ld_last_i) begin
          state_next = S_RUN;
        end
      end
      S_RUN:  if (bus.ld_start_i) state_next = S_LOAD;
      default: state_next = S_HOLD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HOLD;
      cpu_rst  <= 1'b1;
      lane     <= 2'd0;
      word_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      cpu_rst <= (state_next != S_RUN);
      if (bus.ld_start_i) begin
        lane     <= 2'd0;
        word_ptr <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        if (word_done) begin
          lane <= 2'd0;
          if (full) begin
            overflow <= 1'b1;
          end else begin
            word_ptr <= word_ptr + (ADDR_WIDTH + 1)'(1);
          end
        end else begin
          lane <= lane + 2'd1;
        end
      end
    end
  end

  // Only bytes for lanes below the current one are ever read back.
  always_ff @(posedge clk) begin
    if (accept && !word_done) begin
      unique case (lane)
        2'd0: held[23:16] <= bus.ld_data_i;
        2'd1: held[15:8]  <= bus.ld_data_i;
        2'd2: held[7:0]   <= bus.ld_data_i;
        default: ;
      endcase
    end
  end

  // NOTE: the array has no reset; program contents must survive a core reset
  // and clearing them would rule out a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_ptr[ADDR_WIDTH-1:0]] <= word_asm;
    end
  end

  assign bus.rom_data_o = bus.rom_ce_i ? mem[bus.rom_addr_i[ADDR_WIDTH+1:2]] : 32'h0;
  assign bus.ld_ready_o = ready;
  assign unused_addr    = ^{bus.rom_addr_i[31:ADDR_WIDTH+2], bus.rom_addr_i[1:0]};

  assign cpu_rst_o     = cpu_rst;
  assign ld_words_o    = word_ptr;
  assign ld_overflow_o = overflow;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader with a four-word array; every expectation
// is compared in place by check() after the driven inputs have settled.
module tb_inst_rom_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rst;
  logic [AW:0]   words;
  logic          ovf;

  inst_rom_loader_if bus ();

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cpu_rst_o     (cpu_rst),
    .ld_words_o    (words),
    .ld_overflow_o (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i  = b;
    bus.ld_last_i  = last;
    tick();
    bus.ld_valid_i = 1'b0;
    bus.ld_last_i  = 1'b0;
    #1;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = addr;
    #1;
    check(name, bus.rom_data_o, exp);
    tick();
    bus.rom_ce_i   = 1'b0;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.rom_ce_i   = 1'b0;
    bus.rom_addr_i = 32'h10;
    bus.ld_start_i = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_data_i  = 8'h00;
    bus.ld_last_i  = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst",  {31'h0, cpu_rst},          32'd1);
    check("rst_ready",    {31'h0, bus.ld_ready_o},   32'd0);
    check("rst_words",    {{(31-AW){1'b0}}, words},  32'd0);
    check("rst_ovf",      {31'h0, ovf},              32'd0);
    check("rst_data_ce0", bus.rom_data_o,            32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Single full word, release timing
    start_load();
    check("t1_ready_after_start", {31'h0, bus.ld_ready_o}, 32'd1);
    check("t1_held_after_start",  {31'h0, cpu_rst},        32'd1);
    send(8'h3C, 1'b0);
    send(8'h01, 1'b0);
    send(8'h12, 1'b0);
    check("t1_words_mid", {{(31-AW){1'b0}}, words}, 32'd0);
    check("t1_held_mid",  {31'h0, cpu_rst},         32'd1);
    send(8'h34, 1'b1);
    check("t1_release",   {31'h0, cpu_rst},         32'd0);
    check("t1_words",     {{(31-AW){1'b0}}, words}, 32'd1);
    check("t1_ready_run", {31'h0, bus.ld_ready_o},  32'd0);
    fetch("t1_fetch0", 32'h0, 32'h3C011234);

    // Gapped 8-byte image and address aliasing
    start_load();
    begin
      logic [7:0] img [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 8; i++) begin
        send(img[i], i == 7);
        if (i < 7) begin
          if (i == 0) check("t2_ready_in_gap", {31'h0, bus.ld_ready_o}, 32'd1);
          tick();
        end
      end
    end
    check("t2_words", {{(31-AW){1'b0}}, words}, 32'd2);
    fetch("t2_fetch0",      32'h0,  32'h11223344);
    fetch("t2_fetch4",      32'h4,  32'h55667788);
    fetch("t2_fetch6",      32'h6,  32'h55667788);
    fetch("t2_fetch_alias", 32'h4 + 32'(4 * (1 << AW)), 32'h55667788);

    // Partial final word
    start_load();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("t3_words", {{(31-AW){1'b0}}, words}, 32'd1);
    check("t3_run",   {31'h0, cpu_rst},         32'd0);
    check("t3_ready", {31'h0, bus.ld_ready_o},  32'd0);
    fetch("t3_fetch0",      32'h0, 32'hAABB0000);
    fetch("t3_fetch4_kept", 32'h4, 32'h55667788);

    // Overflow: 20 bytes into a 4-word array
    start_load();
    for (int i = 0; i < 20; i++) begin
      send(8'hA0 + 8'(i), i == 19);
      if (i == 15) check("t4_words_full", {{(31-AW){1'b0}}, words}, 32'd4);
    end
    check("t4_words_sat", {{(31-AW){1'b0}}, words}, 32'd4);
    check("t4_ovf",       {31'h0, ovf},             32'd1);
    fetch("t4_fetch0_kept", 32'h0, 32'hA0A1A2A3);
    fetch("t4_fetch3",      32'hC, 32'hACADAEAF);
    start_load();
    check("t4_ovf_cleared",   {31'h0, ovf},             32'd0);
    check("t4_words_cleared", {{(31-AW){1'b0}}, words}, 32'd0);
    check("t4_held_again",    {31'h0, cpu_rst},         32'd1);

    // Start colliding with a byte mid-word
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    bus.ld_start_i = 1'b1;
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i  = 8'hFF;
    #1;
    check("t5_ready_blocked", {31'h0, bus.ld_ready_o}, 32'd0);
    tick();
    bus.ld_start_i = 1'b0;
    bus.ld_valid_i = 1'b0;
    #1;
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b1);
    check("t5_words", {{(31-AW){1'b0}}, words}, 32'd1);
    fetch("t5_fetch0", 32'h0, 32'hDEADBEEF);

    // Reset mid-load
    start_load();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    send(8'h9A, 1'b0);
    send(8'hBC, 1'b0);
    check("t6_words_before", {{(31-AW){1'b0}}, words}, 32'd1);
    fetch("t6_fetch0_before", 32'h0, 32'h12345678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_cpu_rst", {31'h0, cpu_rst},         32'd1);
    check("t6_words",   {{(31-AW){1'b0}}, words}, 32'd0);
    check("t6_ovf",     {31'h0, ovf},             32'd0);
    check("t6_hold",    {31'h0, bus.ld_ready_o},  32'd0);
    fetch("t6_fetch0_kept", 32'h0, 32'h12345678);
    start_load();
    send(8'hC1, 1'b1);
    check("t6_words_after", {{(31-AW){1'b0}}, words}, 32'd1);
    fetch("t6_partial_dropped", 32'h0, 32'hC1000000);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
